apb_intercon_rr: RTL and testbench

APB_INTERCON_RR -- requirements
Module: apb_intercon_rr

---
 rtl/apb_intercon_rr_if.sv | 28 ++
 rtl/apb_intercon_rr.sv | 172 +++++++++++++++++
 tb/tb_apb_intercon_rr.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_intercon_rr_if.sv
// APB bundle shared by the core side (one lane per master) and the slave side
// (one request lane, one response lane per slave) of apb_intercon_rr.
interface apb_intercon_rr_if #(
    parameter int unsigned NumAddr   = 1,
    parameter int unsigned NumSel    = 1,
    parameter int unsigned NumResp   = 1,
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned DataWidth = 16
);
    logic [NumAddr-1:0][AddrWidth-1:0] paddr;
    logic [NumAddr-1:0]                pwrite;
    logic [NumAddr-1:0]                penable;
    logic [NumAddr-1:0][DataWidth-1:0] pwdata;
    logic [NumSel-1:0]                 psel;
    logic [NumResp-1:0][DataWidth-1:0] prdata;
    logic [NumResp-1:0]                pready;
    logic [NumResp-1:0]                pslverr;

    modport master (
        output paddr, pwrite, penable, pwdata, psel,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, penable, pwdata, psel,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_intercon_rr.sv
// Round-robin APB interconnect: MASTER_PORTS cores share one slave bus, one transfer in flight.
// Define APB_INTERCON_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_intercon_rr #(
    parameter int unsigned MASTER_PORTS   = 4,
    parameter int unsigned SLAVE_PORTS    = 4,
    parameter int unsigned BUS_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_MSB       = 7,
    parameter int unsigned ADDR_LSB       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               reset,
    apb_intercon_rr_if.slave  s_bus,
    apb_intercon_rr_if.master m_bus
);
    localparam int unsigned MW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
    localparam int unsigned SW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
    localparam int unsigned IW = ADDR_MSB - ADDR_LSB + 1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                                 state_q;
    logic [MW-1:0]                          grant_q, last_grant_q;
    logic [SW-1:0]                          sidx_q;
    logic                                   dec_err_q;
    logic [SLAVE_PORTS-1:0]                 m_psel_q;
    logic                                   m_penable_q, m_pwrite_q;
    logic [BUS_WIDTH-1:0]                   m_paddr_q;
    logic [DATA_WIDTH-1:0]                  m_pwdata_q;
    logic [MASTER_PORTS-1:0]                s_pready_q, s_pslverr_q;
    logic [MASTER_PORTS-1:0][DATA_WIDTH-1:0] s_prdata_q;

    logic                   req_any;
    logic [MW-1:0]          win, cand;
    int unsigned            cand_n;
    logic [BUS_WIDTH-1:0]   win_addr;
    logic [IW-1:0]          win_idx;
    logic                   win_dec_err;
    logic [SLAVE_PORTS-1:0] win_sel;

    // PENABLE from the cores plays no part in arbitration.
    logic [MASTER_PORTS-1:0] unused_penable;
    assign unused_penable = s_bus.penable;

`ifdef APB_INTERCON_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_q;
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES;
`endif

    // Search starts one past the last grant so every requester is served in turn.
    always_comb begin
        req_any = 1'b0;
        win     = last_grant_q;
        cand    = '0;
        cand_n  = 0;
        for (int unsigned i = 1; i <= MASTER_PORTS; i++) begin
            cand_n = 32'(last_grant_q) + i;
            if (cand_n >= MASTER_PORTS) cand_n = cand_n - MASTER_PORTS;
            cand = MW'(cand_n);
            if (!req_any && s_bus.psel[cand]) begin
                req_any = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        win_addr    = s_bus.paddr[win];
        win_idx     = win_addr[ADDR_MSB:ADDR_LSB];
        win_dec_err = (32'(win_idx) >= SLAVE_PORTS);
        win_sel     = '0;
        for (int unsigned j = 0; j < SLAVE_PORTS; j++) win_sel[j] = (32'(win_idx) == j);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= MW'(MASTER_PORTS - 1);
            sidx_q       <= '0;
            dec_err_q    <= 1'b0;
            m_psel_q     <= '0;
            m_penable_q  <= 1'b0;
            m_pwrite_q   <= 1'b0;
            m_paddr_q    <= '0;
            m_pwdata_q   <= '0;
            s_pready_q   <= '0;
            s_pslverr_q  <= '0;
            s_prdata_q   <= '0;
`ifdef APB_INTERCON_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            s_pready_q  <= '0;
            s_pslverr_q <= '0;
            case (state_q)
                StIdle: begin
                    if (req_any) begin
                        grant_q      <= win;
                        last_grant_q <= win;
                        sidx_q       <= SW'(win_idx);
                        dec_err_q    <= win_dec_err;
                        m_psel_q     <= win_sel;
                        m_paddr_q    <= win_addr;
                        m_pwrite_q   <= s_bus.pwrite[win];
                        m_pwdata_q   <= s_bus.pwdata[win];
                        state_q      <= StSetup;
                    end
                end
                StSetup: begin
                    if (dec_err_q) begin
                        s_pready_q[grant_q]  <= 1'b1;
                        s_pslverr_q[grant_q] <= 1'b1;
                        s_prdata_q[grant_q]  <= '0;
                        m_paddr_q            <= '0;
                        m_pwrite_q           <= 1'b0;
                        m_pwdata_q           <= '0;
                        state_q              <= StIdle;
                    end else begin
                        m_penable_q <= 1'b1;
`ifdef APB_INTERCON_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    if (m_bus.pready[sidx_q]) begin
                        s_pready_q[grant_q]  <= 1'b1;
                        s_pslverr_q[grant_q] <= m_bus.pslverr[sidx_q];
                        s_prdata_q[grant_q]  <= m_pwrite_q ? '0 : m_bus.prdata[sidx_q];
                        m_psel_q             <= '0;
                        m_penable_q          <= 1'b0;
                        m_paddr_q            <= '0;
                        m_pwrite_q           <= 1'b0;
                        m_pwdata_q           <= '0;
                        state_q              <= StIdle;
                    end
`ifdef APB_INTERCON_TIMEOUT_EN
                    else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        s_pready_q[grant_q]  <= 1'b1;
                        s_pslverr_q[grant_q] <= 1'b1;
                        s_prdata_q[grant_q]  <= '0;
                        m_psel_q             <= '0;
                        m_penable_q          <= 1'b0;
                        m_paddr_q            <= '0;
                        m_pwrite_q           <= 1'b0;
                        m_pwdata_q           <= '0;
                        state_q              <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_bus.psel       = m_psel_q;
    assign m_bus.penable[0] = m_penable_q;
    assign m_bus.pwrite[0]  = m_pwrite_q;
    assign m_bus.paddr[0]   = m_paddr_q;
    assign m_bus.pwdata[0]  = m_pwdata_q;
    assign s_bus.pready     = s_pready_q;
    assign s_bus.pslverr    = s_pslverr_q;
    assign s_bus.prdata     = s_prdata_q;
endmodule

// File: tb/tb_apb_intercon_rr.sv
// Scoreboard bench for apb_intercon_rr: cores push expected completions, a monitor pops them.
module tb_apb_intercon_rr;
    localparam int unsigned NM  = 4;
    localparam int unsigned NS  = 4;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 8;

    logic clk;
    logic reset;

    apb_intercon_rr_if #(.NumAddr(NM), .NumSel(NM), .NumResp(NM), .AddrWidth(AW),
                         .DataWidth(DW)) s_if ();
    apb_intercon_rr_if #(.NumAddr(1), .NumSel(NS), .NumResp(NS), .AddrWidth(AW),
                         .DataWidth(DW)) m_if ();

    apb_intercon_rr #(
        .MASTER_PORTS  (NM),
        .SLAVE_PORTS   (NS),
        .BUS_WIDTH     (AW),
        .DATA_WIDTH    (DW),
        .ADDR_MSB      (7),
        .ADDR_LSB      (4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .s_bus(s_if),
        .m_bus(m_if)
    );

    typedef struct {
        int            mst;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;
    int   acc_cnt  = 0;

    logic [DW-1:0] rdata_cfg [NS];
    int            wait_cfg  [NS];
    logic          err_cfg   [NS];
    logic          hang      [NS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: ready after wait_cfg ACCESS cycles unless hung.
    always_comb begin
        m_if.pready  = '0;
        m_if.pslverr = '0;
        m_if.prdata  = '0;
        for (int j = 0; j < NS; j++) begin
            m_if.pready[j]  = m_if.psel[j] & m_if.penable[0] & ~hang[j] & (acc_cnt >= wait_cfg[j]);
            m_if.pslverr[j] = err_cfg[j];
            m_if.prdata[j]  = rdata_cfg[j];
        end
    end

    always @(posedge clk) begin
        acc_cnt <= (m_if.penable[0] && !(|m_if.pready)) ? acc_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (|s_if.pready) begin
            check_eq("cpl_onehot", $countones(s_if.pready), 1);
            for (int i = 0; i < NM; i++) begin
                if (s_if.pready[i]) begin
                    check_eq("sb_nonempty", (sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check_eq("cpl_mst", i, e.mst);
                        check_eq("cpl_rdata", s_if.prdata[i], e.data);
                        check_eq("cpl_err", s_if.pslverr[i], e.err);
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic drive_req(input int m, input logic [AW-1:0] addr, input logic wr,
                             input logic [DW-1:0] wd, input bit push);
        exp_t e;
        int   idx;
        idx   = int'(addr[7:4]);
        e.mst = m;
        if (idx >= NS) begin
            e.data = '0;
            e.err  = 1'b1;
        end else begin
            e.data = wr ? '0 : rdata_cfg[idx];
            e.err  = err_cfg[idx];
`ifdef APB_INTERCON_TIMEOUT_EN
            if (hang[idx]) begin
                e.data = '0;
                e.err  = 1'b1;
            end
`endif
        end
        if (push) sb_q.push_back(e);
        s_if.paddr[m]   = addr;
        s_if.pwrite[m]  = wr;
        s_if.pwdata[m]  = wd;
        s_if.psel[m]    = 1'b1;
        s_if.penable[m] = 1'b1;
    endtask

    task automatic drop(input int m);
        s_if.psel[m]    = 1'b0;
        s_if.penable[m] = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output int cyc, output int pen);
        cyc = 0;
        pen = 0;
        while (done_cnt < target && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
            if (m_if.penable[0]) pen++;
        end
        check_eq("wait_done", done_cnt, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int base, cyc, pen;
        reset        = 1'b0;
        s_if.paddr   = '0;
        s_if.pwrite  = '0;
        s_if.penable = '0;
        s_if.pwdata  = '0;
        s_if.psel    = '0;
        rdata_cfg    = '{16'hA000, 16'hC0DE, 16'hBEEF, 16'h3333};
        wait_cfg     = '{0, 0, 0, 0};
        err_cfg      = '{1'b0, 1'b0, 1'b0, 1'b0};
        hang         = '{1'b0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check_eq("rst_psel", m_if.psel, 0);
        check_eq("rst_pen", m_if.penable, 0);
        check_eq("rst_paddr", m_if.paddr, 0);
        check_eq("rst_pwdata", m_if.pwdata, 0);
        check_eq("rst_spready", s_if.pready, 0);
        check_eq("rst_sprdata", s_if.prdata, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;

        // Single read with exact phase timing.
        base = done_cnt;
        drive_req(2, 16'h0025, 1'b0, '0, 1'b1);
        @(negedge clk); #1;
        check_eq("setup_psel", m_if.psel, 4'b0100);
        check_eq("setup_pen", m_if.penable, 0);
        check_eq("setup_paddr", m_if.paddr, 16'h0025);
        @(negedge clk); #1;
        check_eq("access_pen", m_if.penable, 1);
        check_eq("access_psel", m_if.psel, 4'b0100);
        wait_done(base + 1, 4, cyc, pen);
        drop(2);
        check_eq("read_lat", cyc, 1);
        @(negedge clk); #1;
        check_eq("pready_pulse", s_if.pready, 0);
        check_eq("prdata_hold", s_if.prdata[2], 16'hBEEF);
        check_eq("idle_psel", m_if.psel, 0);
        check_eq("idle_paddr", m_if.paddr, 0);

        // Decode error.
        base = done_cnt;
        drive_req(1, 16'h0050, 1'b1, 16'h5A5A, 1'b1);
        @(negedge clk); #1;
        check_eq("dec_psel", m_if.psel, 0);
        wait_done(base + 1, 4, cyc, pen);
        drop(1);
        check_eq("dec_lat", cyc, 1);

        // Wait states with slave error.
        wait_cfg[0] = 3;
        err_cfg[0]  = 1'b1;
        base = done_cnt;
        drive_req(0, 16'h0003, 1'b0, '0, 1'b1);
        wait_done(base + 1, 20, cyc, pen);
        drop(0);
        check_eq("wait_pen", pen, 4);
        check_eq("wait_lat", cyc, 6);
        wait_cfg[0] = 0;
        err_cfg[0]  = 1'b0;

        // Requester drops PSEL after SETUP; write still completes.
        base = done_cnt;
        drive_req(3, 16'h0011, 1'b1, 16'h1234, 1'b1);
        @(negedge clk); #1;
        check_eq("mid_pwdata", m_if.pwdata, 16'h1234);
        check_eq("mid_pwrite", m_if.pwrite, 1);
        drop(3);
        wait_done(base + 1, 6, cyc, pen);

        // Round-robin among 0,1,3 after reset.
        do_reset();
        base = done_cnt;
        drive_req(0, 16'h0010, 1'b0, '0, 1'b1);
        drive_req(1, 16'h0020, 1'b0, '0, 1'b1);
        drive_req(3, 16'h0030, 1'b1, 16'h7777, 1'b1);
        drive_req(0, 16'h0010, 1'b0, '0, 1'b1);
        wait_done(base + 4, 24, cyc, pen);
        drop(0);
        drop(1);
        drop(3);
        repeat (3) @(negedge clk);
        #1;
        check_eq("rr_no_extra", done_cnt, base + 4);

        // Asynchronous reset during ACCESS.
        hang[3] = 1'b1;
        base = done_cnt;
        drive_req(1, 16'h0030, 1'b0, '0, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check_eq("pre_rst_pen", m_if.penable, 1);
        reset = 1'b0;
        #1;
        check_eq("async_psel", m_if.psel, 0);
        check_eq("async_pen", m_if.penable, 0);
        check_eq("async_paddr", m_if.paddr, 0);
        drop(1);
        hang[3] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        check_eq("post_rst_pready", s_if.pready, 0);
        drive_req(0, 16'h0002, 1'b0, '0, 1'b1);
        drive_req(2, 16'h0021, 1'b0, '0, 1'b1);
        wait_done(base + 1, 6, cyc, pen);
        drop(0);
        wait_done(base + 2, 6, cyc, pen);
        drop(2);

        // Slave that never answers.
        hang[2] = 1'b1;
        base = done_cnt;
`ifdef APB_INTERCON_TIMEOUT_EN
        drive_req(3, 16'h0020, 1'b0, '0, 1'b1);
        wait_done(base + 1, 30, cyc, pen);
        drop(3);
        check_eq("tmo_pen", pen, TMO);
        @(negedge clk); #1;
        check_eq("tmo_idle_psel", m_if.psel, 0);
        hang[2] = 1'b0;
`else
        drive_req(3, 16'h0020, 1'b0, '0, 1'b0);
        repeat (12) @(negedge clk);
        #1;
        check_eq("hang_pen", m_if.penable, 1);
        check_eq("hang_done", done_cnt, base);
        hang[2] = 1'b0;
        drive_req(3, 16'h0020, 1'b0, '0, 1'b1);
        wait_done(base + 1, 4, cyc, pen);
        drop(3);
        check_eq("hang_release_lat", cyc, 1);
`endif

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
